// File: rtl/uart_line_loader_pkg.sv
// Shared constants and types for the UART-to-frame-buffer line loader.
// LINES/PIXELS defaults are also used by the video generator and the BRAM.
package uart_line_loader_pkg;

   localparam int LINES_DEF  = 608;
   localparam int PIXELS_DEF = 300;

   localparam logic [7:0] CH_COMMIT = 8'h2B;  // '+'
   localparam logic [7:0] CH_HOME   = 8'h23;  // '#'
   localparam logic [7:0] CH_CR     = 8'h0D;
   localparam logic [7:0] CH_LF     = 8'h0A;
   localparam logic [7:0] CH_SP     = 8'h20;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_COLLECT,
      ST_WRITE
   } state_e;

   function automatic logic is_filler(input logic [7:0] ch);
      return (ch == CH_CR) || (ch == CH_LF) || (ch == CH_SP);
   endfunction

endpackage

// File: rtl/ascii_hex_decode.sv
// Combinational ASCII hex-digit decoder: one byte in, {is_hex, nibble} out.
// Kept standalone so later command parsers can reuse it.
module ascii_hex_decode (
   input  logic [7:0] char_i,
   output logic       is_hex_o,
   output logic [3:0] nibble_o
);

   always_comb begin
      is_hex_o = 1'b0;
      nibble_o = 4'h0;
      if (char_i >= 8'h30 && char_i <= 8'h39) begin
         is_hex_o = 1'b1;
         nibble_o = 4'(char_i - 8'h30);
      end else if (char_i >= 8'h41 && char_i <= 8'h46) begin
         is_hex_o = 1'b1;
         nibble_o = 4'(char_i - 8'h37);
      end else if (char_i >= 8'h61 && char_i <= 8'h66) begin
         is_hex_o = 1'b1;
         nibble_o = 4'(char_i - 8'h57);
      end
   end

endmodule

// File: rtl/uart_line_loader.sv
// Parses hex digits from the UART receiver into one pixel line and commits it
// to the frame-buffer BRAM with a single write per '+' character.
module uart_line_loader
   import uart_line_loader_pkg::*;
#(
   parameter int LINES  = LINES_DEF,
   parameter int PIXELS = PIXELS_DEF,
   parameter int ADDR_W = 10
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              rx_ready_i,
   input  logic [7:0]        rx_data_i,
   output logic              wr_en_o,
   output logic [ADDR_W-1:0] wr_addr_o,
   output logic [PIXELS-1:0] wr_data_o,
   output logic [ADDR_W-1:0] line_index_o,
   output logic              frame_done_o,
   output logic [7:0]        err_count_o
);

   localparam int NIBS  = PIXELS / 4;
   localparam int NIB_W = $clog2(NIBS + 1);

   state_e              state_q, state_d;
   logic                rx_ready_q;
   logic                hold_valid_q, hold_valid_d;
   logic [7:0]          hold_data_q, hold_data_d;
   logic [PIXELS-1:0]   line_buf_q, line_buf_d;
   logic [NIB_W-1:0]    nib_cnt_q, nib_cnt_d;
   logic [ADDR_W-1:0]   line_index_q, line_index_d;
   logic                wr_en_q, wr_en_d;
   logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
   logic [PIXELS-1:0]   wr_data_q, wr_data_d;
   logic                frame_done_q, frame_done_d;
   logic [7:0]          err_count_q, err_count_d;

   logic       accept;
   logic       process;
   logic       err_inc;
   logic [7:0] cur_byte;
   logic       is_hex;
   logic [3:0] nibble;

   // Rising edge of the level-style ready flag gives one acceptance per byte.
   assign accept   = rx_ready_i && !rx_ready_q;
   assign cur_byte = hold_valid_q ? hold_data_q : rx_data_i;

   ascii_hex_decode u_hex (
      .char_i   (cur_byte),
      .is_hex_o (is_hex),
      .nibble_o (nibble)
   );

   always_comb begin
      // NOTE: every _d gets a default before any branch so no latch can be inferred.
      state_d      = state_q;
      hold_valid_d = hold_valid_q;
      hold_data_d  = hold_data_q;
      line_buf_d   = line_buf_q;
      nib_cnt_d    = nib_cnt_q;
      line_index_d = line_index_q;
      wr_en_d      = 1'b0;
      wr_addr_d    = wr_addr_q;
      wr_data_d    = wr_data_q;
      frame_done_d = 1'b0;
      err_count_d  = err_count_q;
      process      = 1'b0;
      err_inc      = 1'b0;

      if (state_q == ST_WRITE) begin
         state_d = ST_IDLE;
         if (accept) begin
            hold_valid_d = 1'b1;
            hold_data_d  = rx_data_i;
         end
      end else if (hold_valid_q) begin
         // Drain the parked byte first; a byte arriving now takes its place.
         process      = 1'b1;
         hold_valid_d = accept;
         if (accept) hold_data_d = rx_data_i;
      end else begin
         process = accept;
      end

      if (process) begin
         if (is_hex) begin
            if (nib_cnt_q < NIB_W'(NIBS)) begin
               line_buf_d[4*int'(nib_cnt_q) +: 4] = line_buf_q[4*int'(nib_cnt_q) +: 4] | nibble;
               nib_cnt_d = nib_cnt_q + NIB_W'(1);
               state_d   = ST_COLLECT;
            end else begin
               err_inc = 1'b1;
            end
         end else if (cur_byte == CH_COMMIT) begin
            wr_en_d    = 1'b1;
            wr_addr_d  = line_index_q;
            wr_data_d  = line_buf_q;
            line_buf_d = '0;
            nib_cnt_d  = '0;
            state_d    = ST_WRITE;
            if (line_index_q == ADDR_W'(LINES - 1)) begin
               line_index_d = '0;
               frame_done_d = 1'b1;
            end else begin
               line_index_d = line_index_q + ADDR_W'(1);
            end
         end else if (cur_byte == CH_HOME) begin
            line_buf_d   = '0;
            nib_cnt_d    = '0;
            line_index_d = '0;
            state_d      = ST_IDLE;
         end else if (!is_filler(cur_byte)) begin
            err_inc = 1'b1;
         end
      end

      if (err_inc && err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= ST_IDLE;
         // Set high so a byte already valid when reset releases is not taken.
         rx_ready_q   <= 1'b1;
         hold_valid_q <= 1'b0;
         hold_data_q  <= '0;
         // NOTE: line_buf is a plain register (not a RAM), so clearing it on reset is cheap and required.
         line_buf_q   <= '0;
         nib_cnt_q    <= '0;
         line_index_q <= '0;
         wr_en_q      <= 1'b0;
         wr_addr_q    <= '0;
         wr_data_q    <= '0;
         frame_done_q <= 1'b0;
         err_count_q  <= '0;
      end else begin
         state_q      <= state_d;
         rx_ready_q   <= rx_ready_i;
         hold_valid_q <= hold_valid_d;
         hold_data_q  <= hold_data_d;
         line_buf_q   <= line_buf_d;
         nib_cnt_q    <= nib_cnt_d;
         line_index_q <= line_index_d;
         wr_en_q      <= wr_en_d;
         wr_addr_q    <= wr_addr_d;
         wr_data_q    <= wr_data_d;
         frame_done_q <= frame_done_d;
         err_count_q  <= err_count_d;
      end
   end

   assign wr_en_o      = wr_en_q;
   assign wr_addr_o    = wr_addr_q;
   assign wr_data_o    = wr_data_q;
   assign line_index_o = line_index_q;
   assign frame_done_o = frame_done_q;
   assign err_count_o  = err_count_q;

endmodule

// File: tb/tb_uart_line_loader.sv
// Directed bench for uart_line_loader: sends ASCII strings and checks the
// logged BRAM writes, line pointer and reject counter against hand values.
module tb_uart_line_loader;

   localparam int LINES  = 608;
   localparam int PIXELS = 300;
   localparam int ADDR_W = 10;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              rx_ready = 1'b0;
   logic [7:0]        rx_data = 8'h00;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [PIXELS-1:0] wr_data;
   logic [ADDR_W-1:0] line_index;
   logic              frame_done;
   logic [7:0]        err_count;

   int n_vec = 0;
   int n_err = 0;

   logic [ADDR_W-1:0] log_addr[$];
   logic [PIXELS-1:0] log_data[$];
   logic              log_fd[$];
   int                fd_total = 0;

   always #5 clk = ~clk;

   uart_line_loader #(.LINES(LINES), .PIXELS(PIXELS), .ADDR_W(ADDR_W)) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .rx_ready_i   (rx_ready),
      .rx_data_i    (rx_data),
      .wr_en_o      (wr_en),
      .wr_addr_o    (wr_addr),
      .wr_data_o    (wr_data),
      .line_index_o (line_index),
      .frame_done_o (frame_done),
      .err_count_o  (err_count)
   );

   // Write monitor: a strobe longer than one cycle shows up as extra entries.
   always @(negedge clk) begin
      if (wr_en === 1'b1) begin
         log_addr.push_back(wr_addr);
         log_data.push_back(wr_data);
         log_fd.push_back(frame_done);
      end
      if (frame_done === 1'b1) fd_total++;
   end

   task automatic apply_reset();
      @(negedge clk);
      rst = 1'b1;
      rx_ready = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      rx_data  = b;
      rx_ready = 1'b1;
      repeat (2) @(negedge clk);
      rx_ready = 1'b0;
      @(negedge clk);
   endtask

   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++) send_byte(s[i]);
   endtask

   task automatic test_reset();
      apply_reset();
      if (wr_en !== 1'b0) begin n_err++; $display("FAIL reset_wr_en: got %b want 0", wr_en); end
      n_vec++;
      if (wr_addr !== '0) begin n_err++; $display("FAIL reset_wr_addr: got %0d want 0", wr_addr); end
      n_vec++;
      if (wr_data !== '0) begin n_err++; $display("FAIL reset_wr_data: got %h want 0", wr_data); end
      n_vec++;
      if (line_index !== '0) begin n_err++; $display("FAIL reset_line_index: got %0d want 0", line_index); end
      n_vec++;
      if (frame_done !== 1'b0) begin n_err++; $display("FAIL reset_frame_done: got %b want 0", frame_done); end
      n_vec++;
      if (err_count !== 8'd0) begin n_err++; $display("FAIL reset_err_count: got %0d want 0", err_count); end
      n_vec++;
   endtask

   task automatic test_basic_commit();
      int base;
      logic [PIXELS-1:0] exp;
      apply_reset();
      base = log_addr.size();
      send_str("F0+");
      repeat (3) @(negedge clk);
      exp = '0;
      exp[7:0] = 8'h0F;
      if (log_addr.size() - base !== 1) begin n_err++; $display("FAIL basic_write_count: got %0d want 1", log_addr.size() - base); end
      n_vec++;
      if (log_addr.size() > base) begin
         if (log_addr[base] !== 10'd0) begin n_err++; $display("FAIL basic_addr: got %0d want 0", log_addr[base]); end
         n_vec++;
         if (log_data[base] !== exp) begin n_err++; $display("FAIL basic_data: got %h want %h", log_data[base], exp); end
         n_vec++;
      end
      if (wr_data !== exp) begin n_err++; $display("FAIL basic_data_held: got %h want %h", wr_data, exp); end
      n_vec++;
      if (line_index !== 10'd1) begin n_err++; $display("FAIL basic_line_index: got %0d want 1", line_index); end
      n_vec++;
      if (err_count !== 8'd0) begin n_err++; $display("FAIL basic_err_count: got %0d want 0", err_count); end
      n_vec++;
   endtask

   task automatic test_home();
      int base;
      logic [PIXELS-1:0] exp0, exp1, exp2;
      apply_reset();
      send_str("5+7");
      base = log_addr.size();
      send_str("#1+2+#8+");
      exp0 = '0; exp0[0] = 1'b1;
      exp1 = '0; exp1[1] = 1'b1;
      exp2 = '0; exp2[3] = 1'b1;
      if (log_addr.size() - base !== 3) begin n_err++; $display("FAIL home_write_count: got %0d want 3", log_addr.size() - base); end
      n_vec++;
      if (log_addr.size() - base == 3) begin
         if (log_addr[base] !== 10'd0 || log_data[base] !== exp0) begin
            n_err++; $display("FAIL home_w0: got addr %0d data %h want addr 0 data %h", log_addr[base], log_data[base], exp0);
         end
         n_vec++;
         if (log_addr[base+1] !== 10'd1 || log_data[base+1] !== exp1) begin
            n_err++; $display("FAIL home_w1: got addr %0d data %h want addr 1 data %h", log_addr[base+1], log_data[base+1], exp1);
         end
         n_vec++;
         if (log_addr[base+2] !== 10'd0 || log_data[base+2] !== exp2) begin
            n_err++; $display("FAIL home_w2: got addr %0d data %h want addr 0 data %h", log_addr[base+2], log_data[base+2], exp2);
         end
         n_vec++;
      end
      if (line_index !== 10'd1) begin n_err++; $display("FAIL home_line_index: got %0d want 1", line_index); end
      n_vec++;
   endtask

   task automatic test_overflow();
      int base;
      logic [PIXELS-1:0] exp;
      apply_reset();
      base = log_addr.size();
      for (int i = 0; i < 76; i++) send_byte(8'h66);
      if (err_count !== 8'd1) begin n_err++; $display("FAIL overflow_err_count: got %0d want 1", err_count); end
      n_vec++;
      send_byte(8'h2B);
      exp = '1;
      if (log_addr.size() - base !== 1) begin n_err++; $display("FAIL overflow_write_count: got %0d want 1", log_addr.size() - base); end
      n_vec++;
      if (log_addr.size() > base) begin
         if (log_data[base] !== exp) begin n_err++; $display("FAIL overflow_data: got %h want %h", log_data[base], exp); end
         n_vec++;
      end
   endtask

   task automatic test_frame_wrap();
      int base;
      logic [PIXELS-1:0] exp;
      apply_reset();
      base = fd_total;
      for (int i = 0; i < LINES - 1; i++) send_byte(8'h2B);
      if (line_index !== 10'd607) begin n_err++; $display("FAIL wrap_pre_index: got %0d want 607", line_index); end
      n_vec++;
      if (fd_total - base !== 0) begin n_err++; $display("FAIL wrap_early_frame_done: got %0d pulses want 0", fd_total - base); end
      n_vec++;
      base = log_addr.size();
      send_str("a+");
      exp = '0;
      exp[3:0] = 4'hA;
      if (log_addr.size() - base !== 1) begin n_err++; $display("FAIL wrap_write_count: got %0d want 1", log_addr.size() - base); end
      n_vec++;
      if (log_addr.size() > base) begin
         if (log_addr[base] !== 10'd607) begin n_err++; $display("FAIL wrap_addr: got %0d want 607", log_addr[base]); end
         n_vec++;
         if (log_data[base] !== exp) begin n_err++; $display("FAIL wrap_data: got %h want %h", log_data[base], exp); end
         n_vec++;
         if (log_fd[base] !== 1'b1) begin n_err++; $display("FAIL wrap_frame_done_with_wr_en: got %b want 1", log_fd[base]); end
         n_vec++;
      end
      if (fd_total !== 1) begin n_err++; $display("FAIL wrap_frame_done_total: got %0d want 1", fd_total); end
      n_vec++;
      if (line_index !== 10'd0) begin n_err++; $display("FAIL wrap_line_index: got %0d want 0", line_index); end
      n_vec++;
   endtask

   task automatic test_reject();
      int base;
      logic [PIXELS-1:0] exp;
      apply_reset();
      base = log_addr.size();
      send_str("3Zg\r\n +");
      exp = '0;
      exp[3:0] = 4'h3;
      if (log_addr.size() - base !== 1) begin n_err++; $display("FAIL reject_write_count: got %0d want 1", log_addr.size() - base); end
      n_vec++;
      if (log_addr.size() > base) begin
         if (log_data[base] !== exp) begin n_err++; $display("FAIL reject_data: got %h want %h", log_data[base], exp); end
         n_vec++;
      end
      if (err_count !== 8'd2) begin n_err++; $display("FAIL reject_err_count: got %0d want 2", err_count); end
      n_vec++;
      // One byte held valid for 200 cycles must be taken once.
      base = log_addr.size();
      @(negedge clk);
      rx_data  = 8'h35;
      rx_ready = 1'b1;
      repeat (200) @(negedge clk);
      rx_ready = 1'b0;
      @(negedge clk);
      send_byte(8'h2B);
      exp = '0;
      exp[3:0] = 4'h5;
      if (log_addr.size() - base !== 1) begin n_err++; $display("FAIL long_ready_write_count: got %0d want 1", log_addr.size() - base); end
      n_vec++;
      if (log_addr.size() > base) begin
         if (log_data[base] !== exp) begin n_err++; $display("FAIL long_ready_data: got %h want %h", log_data[base], exp); end
         n_vec++;
      end
   endtask

   task automatic test_back_to_back();
      int base;
      apply_reset();
      base = log_addr.size();
      @(negedge clk); rx_data = 8'h2B; rx_ready = 1'b1;
      @(negedge clk); rx_ready = 1'b0;
      @(negedge clk); rx_ready = 1'b1;
      @(negedge clk); rx_ready = 1'b0;
      repeat (3) @(negedge clk);
      if (log_addr.size() - base !== 2) begin n_err++; $display("FAIL b2b_write_count: got %0d want 2", log_addr.size() - base); end
      n_vec++;
      if (log_addr.size() - base == 2) begin
         if (log_addr[base] !== 10'd0 || log_addr[base+1] !== 10'd1) begin
            n_err++; $display("FAIL b2b_addrs: got %0d,%0d want 0,1", log_addr[base], log_addr[base+1]);
         end
         n_vec++;
      end
      if (line_index !== 10'd2) begin n_err++; $display("FAIL b2b_line_index: got %0d want 2", line_index); end
      n_vec++;
   endtask

   task automatic test_reset_midline();
      int base;
      apply_reset();
      send_str("5+!ABC");
      // Reset with a byte valid across release; that byte must be ignored.
      @(negedge clk);
      rx_data  = 8'h37;
      rx_ready = 1'b1;
      rst      = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      rx_ready = 1'b0;
      @(negedge clk);
      if (wr_addr !== '0 || wr_data !== '0) begin n_err++; $display("FAIL midreset_wr_regs: got addr %0d data %h want 0 0", wr_addr, wr_data); end
      n_vec++;
      if (line_index !== '0) begin n_err++; $display("FAIL midreset_line_index: got %0d want 0", line_index); end
      n_vec++;
      if (err_count !== 8'd0) begin n_err++; $display("FAIL midreset_err_count: got %0d want 0", err_count); end
      n_vec++;
      base = log_addr.size();
      send_byte(8'h2B);
      if (log_addr.size() - base !== 1) begin n_err++; $display("FAIL midreset_write_count: got %0d want 1", log_addr.size() - base); end
      n_vec++;
      if (log_addr.size() > base) begin
         if (log_addr[base] !== 10'd0 || log_data[base] !== '0) begin
            n_err++; $display("FAIL midreset_write: got addr %0d data %h want addr 0 data 0", log_addr[base], log_data[base]);
         end
         n_vec++;
      end
   endtask

   initial begin
      test_reset();
      test_basic_commit();
      test_home();
      test_overflow();
      test_frame_wrap();
      test_reject();
      test_back_to_back();
      test_reset_midline();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/uart_line_loader.md
# uart_line_loader

Byte-stream parser between the UART receiver and the frame-buffer BRAM write port. It consumes ASCII bytes from the receiver and assembles hex digits into one horizontal line of monochrome pixels. On each line-commit character it issues a single BRAM write and advances the line pointer. This removes ad-hoc parsing from the top level and gives the video generator a fully defined frame-buffer update protocol.

## Interface
- LINES, 608: number of frame-buffer lines (write addresses 0..LINES-1).
- PIXELS, 300: bits per line; must be a multiple of 4.
- ADDR_W, 10: BRAM address width; 2**ADDR_W ≥ LINES.
- clk  in  1  receiver/BRAM write clock (27 MHz domain).
- rst  in  1  reset, synchronous, active-high.
- rx_ready  in  1  receiver byte-valid level; stays high from byte completion until the next start bit.
- rx_data  in  8  received byte; stable while rx_ready high.
- wr_en  out  1  one-cycle BRAM write strobe.
- wr_addr  out  ADDR_W  BRAM write address.
- wr_data  out  PIXELS  line data; bit k = pixel k (left-most on screen = bit 0).
- line_index  out  ADDR_W  line the next commit will write.
- frame_done  out  1  one-cycle pulse when line LINES-1 is committed.
- err_count  out  8  saturating count of rejected bytes.

## Operation
- Byte acceptance: rx_ready is registered into rx_ready_q. A byte is accepted in cycle n when rx_ready=1 and rx_ready_q=0 (rising edge). Exactly one acceptance occurs per byte, however long rx_ready stays high.
- Character classes:
  - '0'-'9', 'A'-'F', 'a'-'f' → nibble.
  - '+' → commit.
  - '#' → home.
  - CR (0x0D), LF (0x0A), space → ignored silently.
  - Anything else → reject: err_count+1, saturating at 255.
- Nibble: with nib_cnt < PIXELS/4, OR the value into line_buf[4*nib_cnt+3 : 4*nib_cnt] and set nib_cnt+1. Digit MSB lands at the higher pixel index. With nib_cnt = PIXELS/4 (overflow), discard the nibble and count it as a reject.
- Commit: write line_buf to line_index, clear line_buf and nib_cnt, then advance line_index. line_index wraps LINES-1 → 0; frame_done pulses on that wrap. A commit with nib_cnt = 0 writes an all-zero (black) line.
- Home: clear line_buf, nib_cnt and line_index; no write. A partially assembled line is discarded.
- FSM states:
  - IDLE: nib_cnt = 0, nothing pending.
  - COLLECT: nib_cnt > 0.
  - WRITE: one cycle, wr_en = 1.
- FSM transitions:
  - IDLE/COLLECT → WRITE on commit.
  - IDLE/COLLECT → IDLE on home.
  - IDLE → COLLECT on first nibble.
  - WRITE → IDLE unconditionally.
- Byte accepted while in WRITE (not reachable at rated baud): latched into a one-entry hold register and processed in the cycle after WRITE. No byte is lost.
- Reset, including mid-line or during WRITE:
  - wr_en=0, wr_addr=0, wr_data=0, line_index=0, frame_done=0, err_count=0.
  - line_buf, nib_cnt and hold register cleared; FSM in IDLE.
  - rx_ready_q ← 1. A byte already valid at reset release is therefore not accepted.

## Timing
- Commit accepted in cycle n → wr_en=1 in cycle n+1, with wr_addr = line_index before the increment and wr_data = the assembled line.
- wr_addr and wr_data are registered and hold their values until the next commit, so they are stable around the strobe.
- In cycle n+1: line_index shows the incremented value; frame_done coincides with wr_en for line LINES-1.
- Nibble accepted in cycle n → visible in line_buf from cycle n+1. line_buf is internal; it appears on wr_data only on commit.
- Minimum byte spacing at 2.2 Mbaud / 27 MHz is about 120 cycles, so throughput is never a limit.
- All outputs are registered; there are no combinational paths from input to output.

## Structure
- Shared package holds:
  - character constants CH_COMMIT, CH_HOME, CH_CR, CH_LF, CH_SP;
  - default LINES and PIXELS, shared with the video generator and BRAM;
  - FSM state typedef.
- Sub-module ascii_hex_decode (combinational), byte in → {is_hex, nibble[3:0]}. It is reused by future command parsers.

## Test plan
- Reset, then send "F0+": wr_en for exactly one cycle, wr_addr=0, wr_data[7:0]=8'h0F, other bits 0; line_index=1; err_count=0.
- "#", then "1+2+": writes addr0 bit0=1, then addr1 bit1=1. Then "#" followed by "8+": writes addr0 with bit3=1.
- 76 'f' then '+': wr_data all ones (300 bits); err_count=1.
- From line_index=607, send "a+": write to addr 607 with frame_done pulse in the same cycle; line_index=0.
- "3Zg\r\n+": wr_data[3:0]=4'h3; err_count=2; CR/LF not counted. Hold rx_ready high for 200 cycles on a single byte: exactly one acceptance.
- Assert rst after "ABC", then send "+": write to addr 0 with wr_data=0. A byte valid at reset release is ignored.
